// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter
// Function : Packet-level round-robin arbiter in front of a UART transmit
//            pipe. Grant is held from first byte to the byte marked last;
//            a stall watchdog revokes a grant whose owner stops supplying
//            bytes mid-packet.
// Revision : 1.0 - initial release
// ============================================================================
module tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1_200_000,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_push,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_full,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int GW = $clog2(N_REQ);
    localparam logic [GW-1:0] c_LAST_RESET  = GW'(N_REQ - 1);
    localparam logic [31:0]   c_STALL_LIMIT = 32'(TIMEOUT - 1);
    localparam logic          c_WDOG_EN     = (TIMEOUT != 0);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_last_grant;
    logic [GW-1:0] r_grant_id;
    logic [31:0]   r_stall_cnt;
    logic          r_timeout_err;

    logic [GW-1:0] w_sel;
    logic          w_sel_found;
    int            w_scan_idx;
    logic          w_g_valid;
    logic          w_g_last;
    logic          w_xfer;
    logic          w_starved;
    logic          w_expire;

    // Owner's handshake bits and byte; after reset grant_id is 0 so the
    // byte-0 lane is presented, keeping out_data deterministic.
    assign w_g_valid   = req_valid[r_grant_id];
    assign w_g_last    = req_last[r_grant_id];
    assign out_data    = req_data[{r_grant_id, 3'b000} +: WIDTH];
    assign grant_id    = r_grant_id;
    assign busy        = (r_state == S_GRANT);
    assign timeout_err = r_timeout_err;

    // Round-robin pick: first valid requester scanning upward from last_grant+1.
    always_comb begin
        w_sel       = '0;
        w_sel_found = 1'b0;
        w_scan_idx  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_scan_idx = int'(r_last_grant) + k;
            if (w_scan_idx >= N_REQ) begin
                w_scan_idx = w_scan_idx - N_REQ;
            end
            if (!w_sel_found && req_valid[w_scan_idx[GW-1:0]]) begin
                w_sel       = w_scan_idx[GW-1:0];
                w_sel_found = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake and watchdog decode. Handshakes are masked while
    // rst is high so no byte is consumed on the cycle the grant is dropped.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        out_push    = 1'b0;
        w_xfer      = 1'b0;
        w_starved   = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                req_ready[r_grant_id] = !rst && !out_full;
                w_xfer    = !rst && w_g_valid && !out_full;
                out_push  = w_xfer;
                // Back-pressure with data waiting is not starvation.
                w_starved = c_WDOG_EN && !w_g_valid;
                w_expire  = w_starved && (r_stall_cnt == c_STALL_LIMIT);
                if ((w_xfer && w_g_last) || w_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, stall counter and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant  <= c_LAST_RESET;
            r_grant_id    <= '0;
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_expire;
            if (r_state == S_IDLE) begin
                if (w_sel_found) begin
                    r_grant_id  <= w_sel;
                    r_stall_cnt <= '0;
                end
            end else begin
                if (w_xfer) begin
                    if (w_g_last) begin
                        r_last_grant <= r_grant_id;
                    end else begin
                        r_stall_cnt <= '0;
                    end
                end else if (w_expire) begin
                    r_last_grant <= r_grant_id;
                end else if (w_starved) begin
                    r_stall_cnt <= r_stall_cnt + 32'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_arbiter
// Function : Randomised scoreboard bench for tx_arbiter. A packet-level
//            reference model predicts every pushed byte and per-cycle status;
//            a monitor on the falling edge pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 6;
    localparam int NCYC = 4000;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           out_push;
    logic [7:0]     out_data;
    logic           out_full;
    logic [1:0]     grant_id;
    logic           busy;
    logic           timeout_err;

    tx_arbiter #(.N_REQ(N), .TIMEOUT(TO), .WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .out_push   (out_push),
        .out_data   (out_data),
        .out_full   (out_full),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic [1:0] gid;
    } push_t;

    typedef struct {
        int         cyc;
        logic       busy;
        logic [3:0] ready;
        logic       push;
        logic       terr;
        logic [1:0] gid;
    } stat_t;

    push_t exp_push[$];
    stat_t exp_stat[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Requester sources: bytes remaining in current packet and current byte.
    int         src_len[N];
    logic [7:0] src_data[N];
    int         stall_left[N];
    int         full_left;

    // Reference model: who owns the pipe, who owned it last, how long the
    // owner has been silent, and whether a revoke happened last cycle.
    bit m_known;
    bit m_busy;
    int m_owner;
    int m_last;
    int m_stall;
    bit m_terr;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic advance_src(input int i);
        if (src_len[i] <= 1) begin
            src_len[i] = $urandom_range(1, 5);
        end else begin
            src_len[i] = src_len[i] - 1;
        end
        src_data[i] = 8'($urandom);
    endtask

    // Stimulus and reference model.
    initial begin
        bit         xfer;
        bit         n_terr;
        logic [3:0] e_ready;
        int         g;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_full  = 1'b0;
        full_left = 0;
        m_known   = 0;
        m_busy    = 0;
        m_owner   = 0;
        m_last    = N - 1;
        m_stall   = 0;
        m_terr    = 0;
        for (int i = 0; i < N; i++) begin
            src_len[i]    = $urandom_range(1, 5);
            src_data[i]   = 8'($urandom);
            stall_left[i] = 0;
        end

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            rst = (cyc <= 2) || (cyc == 1500) || (cyc == 2501);

            for (int i = 0; i < N; i++) begin
                if (stall_left[i] > 0) begin
                    req_valid[i]  = 1'b0;
                    stall_left[i] = stall_left[i] - 1;
                end else begin
                    req_valid[i] = 1'b1;
                    if ($urandom_range(0, 9) == 0) begin
                        stall_left[i] = $urandom_range(1, 9);
                    end
                end
                req_data[i*8 +: 8] = src_data[i];
                req_last[i]        = (src_len[i] == 1);
            end
            if (full_left > 0) begin
                out_full  = 1'b1;
                full_left = full_left - 1;
            end else begin
                out_full = 1'b0;
                if ($urandom_range(0, 7) == 0) begin
                    full_left = $urandom_range(1, 8);
                end
            end

            // Expected outputs for this cycle.
            xfer    = 0;
            e_ready = '0;
            g       = m_owner;
            if (m_busy && !rst) begin
                if (!out_full) e_ready[g] = 1'b1;
                xfer = req_valid[g] && !out_full;
            end
            if (m_known) begin
                exp_stat.push_back('{cyc, m_busy, e_ready, xfer, m_terr, 2'(m_owner)});
                if (xfer) begin
                    exp_push.push_back('{cyc, src_data[g], 2'(g)});
                end
            end

            // Model advance to the next cycle.
            n_terr = 0;
            if (m_busy) begin
                if (xfer) begin
                    if (src_len[g] == 1) begin
                        m_busy = 0;
                        m_last = g;
                    end else begin
                        m_stall = 0;
                    end
                    advance_src(g);
                end else if (!req_valid[g]) begin
                    if (m_stall + 1 == TO) begin
                        m_busy = 0;
                        m_last = g;
                        n_terr = 1;
                    end else begin
                        m_stall = m_stall + 1;
                    end
                end
            end else if (req_valid != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (!m_busy && req_valid[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        m_busy  = 1;
                        m_stall = 0;
                    end
                end
            end
            m_terr = n_terr;
            if (rst) begin
                m_known = 1;
                m_busy  = 0;
                m_owner = 0;
                m_last  = N - 1;
                m_stall = 0;
                m_terr  = 0;
            end
        end

        @(negedge clk);
        #1;
        chk("push_queue_drained", 32'(exp_push.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor: per-cycle status and every pushed byte against the scoreboard.
    always @(negedge clk) begin
        stat_t s;
        push_t p;
        if (exp_stat.size() > 0 && exp_stat[0].cyc == cyc) begin
            s = exp_stat.pop_front();
            chk("busy",        32'(busy),        32'(s.busy));
            chk("req_ready",   32'(req_ready),   32'(s.ready));
            chk("out_push",    32'(out_push),    32'(s.push));
            chk("timeout_err", 32'(timeout_err), 32'(s.terr));
            chk("grant_id",    32'(grant_id),    32'(s.gid));
        end
        if (out_push === 1'b1) begin
            if (exp_push.size() == 0) begin
                chk("unexpected_push", 32'd1, 32'd0);
            end else begin
                p = exp_push.pop_front();
                chk("push_cycle", 32'(cyc),      32'(p.cyc));
                chk("push_data",  32'(out_data), 32'(p.data));
                chk("push_owner", 32'(grant_id), 32'(p.gid));
            end
        end
    end

endmodule
`default_nettype wire
